// File: rtl/ramtest_pkg.sv
// Shared definitions for the SRAM tester sequencer: state encoding and
// default parameter values used by the sequencer and its button debouncer.
package ramtest_pkg;

    typedef enum logic [2:0] {
        WAIT_FIRST = 3'd0,
        START_F    = 3'd1,
        RUN_F      = 3'd2,
        START_S    = 3'd3,
        RUN_S      = 3'd4,
        CHECK      = 3'd5,
        STOPPED    = 3'd6
    } seq_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 65536;
    localparam int DEF_START_TIMEOUT   = 1024;
    localparam int DEF_BLINK_BITS      = 22;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer on the raw active-low button,
// a stability counter, and a one-cycle pulse on an accepted press.
module btn_debounce
    import ramtest_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          btn_p0;
    logic          btn_p1;
    logic          stable;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clock domain; idle level is released (1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_p0 <= 1'b1;
            btn_p1 <= 1'b1;
        end else begin
            btn_p0 <= btn_n;
            btn_p1 <= btn_p0;
        end
    end

    // Accept a new level only after it differs from the stable one for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn_p1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= btn_p1;
                cnt    <= '0;
                press  <= ~btn_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ramtest_sequencer.sv
// Sequencer around the 8-bit SRAM tester: alternates fast and slow passes,
// keeps pass/failure statistics, handles pause/button, and drives the LED.
module ramtest_sequencer
    import ramtest_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int START_TIMEOUT   = DEF_START_TIMEOUT,
    parameter int BLINK_BITS      = DEF_BLINK_BITS,
    parameter int STOP_ON_FAIL    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       pause,
    input  logic       test_in_progress,
    input  logic       test_result,
    output logic       rstf,
    output logic       rsts,
    output logic       hold,
    output logic [7:0] pass_count,
    output logic       fail_fast,
    output logic       fail_slow,
    output logic       err_timeout,
    output logic       running,
    output logic       led
);

    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(START_TIMEOUT - 1);

    seq_state_t            state;
    logic [TW-1:0]         tmo_cnt;
    logic                  fast_ok;
    logic                  from_slow;
    logic                  press;
    logic                  press_pending;
    logic                  pause_p0;
    logic                  pause_p1;
    logic                  any_flag;
    logic [BLINK_BITS-1:0] blink_cnt;

    // Saturating increment for the pass counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_n),
        .press (press)
    );

    assign any_flag = fail_fast | fail_slow | err_timeout;
    assign hold     = pause_p1;

    // Pause switch synchronizer; its second stage freezes the tester and the sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pause_p0 <= 1'b0;
            pause_p1 <= 1'b0;
        end else begin
            pause_p0 <= pause;
            pause_p1 <= pause_p0;
        end
    end

    // Main sequencing FSM with registered restart requests and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= WAIT_FIRST;
            rstf          <= 1'b0;
            rsts          <= 1'b0;
            tmo_cnt       <= '0;
            fast_ok       <= 1'b0;
            from_slow     <= 1'b0;
            pass_count    <= 8'd0;
            fail_fast     <= 1'b0;
            fail_slow     <= 1'b0;
            err_timeout   <= 1'b0;
            running       <= 1'b1;
            press_pending <= 1'b0;
        end else begin
            if (press) begin
                press_pending <= 1'b1;
            end
            if (!hold) begin
                case (state)
                    WAIT_FIRST: begin
                        // The tester starts a fast pass by itself at power-up; join it if running.
                        if (test_in_progress) begin
                            state <= RUN_F;
                        end else begin
                            state   <= START_F;
                            rstf    <= 1'b1;
                            tmo_cnt <= TMO_LOAD;
                        end
                    end
                    START_F: begin
                        if (test_in_progress) begin
                            rstf  <= 1'b0;
                            state <= RUN_F;
                        end else if (tmo_cnt == '0) begin
                            rstf        <= 1'b0;
                            err_timeout <= 1'b1;
                            running     <= 1'b0;
                            state       <= STOPPED;
                        end else begin
                            tmo_cnt <= tmo_cnt - 1'b1;
                        end
                    end
                    START_S: begin
                        if (test_in_progress) begin
                            rsts  <= 1'b0;
                            state <= RUN_S;
                        end else if (tmo_cnt == '0) begin
                            rsts        <= 1'b0;
                            err_timeout <= 1'b1;
                            running     <= 1'b0;
                            state       <= STOPPED;
                        end else begin
                            tmo_cnt <= tmo_cnt - 1'b1;
                        end
                    end
                    RUN_F: begin
                        if (!test_in_progress) begin
                            fast_ok   <= test_result;
                            fail_fast <= fail_fast | ~test_result;
                            from_slow <= 1'b0;
                            state     <= CHECK;
                        end
                    end
                    RUN_S: begin
                        if (!test_in_progress) begin
                            fail_slow <= fail_slow | ~test_result;
                            if (test_result && fast_ok) begin
                                pass_count <= sat_inc8(pass_count);
                            end
                            from_slow <= 1'b1;
                            state     <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (press_pending) begin
                            pass_count    <= 8'd0;
                            fail_fast     <= 1'b0;
                            fail_slow     <= 1'b0;
                            err_timeout   <= 1'b0;
                            press_pending <= press;
                            rstf          <= 1'b1;
                            tmo_cnt       <= TMO_LOAD;
                            state         <= START_F;
                        end else if ((STOP_ON_FAIL != 0) && any_flag) begin
                            running <= 1'b0;
                            state   <= STOPPED;
                        end else if (from_slow) begin
                            rstf    <= 1'b1;
                            tmo_cnt <= TMO_LOAD;
                            state   <= START_F;
                        end else begin
                            rsts    <= 1'b1;
                            tmo_cnt <= TMO_LOAD;
                            state   <= START_S;
                        end
                    end
                    STOPPED: begin
                        if (press_pending) begin
                            pass_count    <= 8'd0;
                            fail_fast     <= 1'b0;
                            fail_slow     <= 1'b0;
                            err_timeout   <= 1'b0;
                            press_pending <= press;
                            running       <= 1'b1;
                            rstf          <= 1'b1;
                            tmo_cnt       <= TMO_LOAD;
                            state         <= START_F;
                        end
                    end
                    default: begin
                        state <= WAIT_FIRST;
                    end
                endcase
            end
        end
    end

    // Free-running blink counter; its MSB is the blink phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Status LED: dark on any failure, solid when stopped clean, blinking while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= 1'b0;
        end else if (any_flag) begin
            led <= 1'b0;
        end else if (running) begin
            led <= blink_cnt[BLINK_BITS-1];
        end else begin
            led <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ramtest_sequencer.sv
// Directed bench for ramtest_sequencer with a behavioural SRAM tester model.
module tb_ramtest_sequencer;

    localparam int RUN_LEN = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_n = 1'b1;
    logic       pause = 1'b0;
    logic       test_in_progress = 1'b0;
    logic       test_result = 1'b1;
    logic       rstf;
    logic       rsts;
    logic       hold;
    logic [7:0] pass_count;
    logic       fail_fast;
    logic       fail_slow;
    logic       err_timeout;
    logic       running;
    logic       led;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ramtest_sequencer #(
        .DEBOUNCE_CYCLES(8),
        .START_TIMEOUT  (32),
        .BLINK_BITS     (4),
        .STOP_ON_FAIL   (1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_n            (btn_n),
        .pause            (pause),
        .test_in_progress (test_in_progress),
        .test_result      (test_result),
        .rstf             (rstf),
        .rsts             (rsts),
        .hold             (hold),
        .pass_count       (pass_count),
        .fail_fast        (fail_fast),
        .fail_slow        (fail_slow),
        .err_timeout      (err_timeout),
        .running          (running),
        .led              (led)
    );

    // Tester model: 4-flop request synchronizer, fixed run length, configurable result.
    logic [3:0] sync_f = 4'd0;
    logic [3:0] sync_s = 4'd0;
    logic       busy = 1'b0;
    logic       is_slow = 1'b0;
    int         run_cnt = 0;
    int         slow_runs = 0;
    logic       boot_req = 1'b0;
    logic       ignore_rsts = 1'b0;
    logic       fail_all = 1'b0;
    int         fail_slow_at = 0;

    always @(posedge clk) begin
        if (!hold) begin
            sync_f <= {sync_f[2:0], rstf};
            sync_s <= {sync_s[2:0], rsts};
            if (busy) begin
                run_cnt <= run_cnt - 1;
                if (run_cnt == 1) begin
                    busy             <= 1'b0;
                    test_in_progress <= 1'b0;
                    test_result      <= !(fail_all || (is_slow && (slow_runs + 1 == fail_slow_at)));
                    if (is_slow) slow_runs <= slow_runs + 1;
                end
            end else if (sync_f[3] || boot_req) begin
                busy <= 1'b1; is_slow <= 1'b0; run_cnt <= RUN_LEN; test_in_progress <= 1'b1;
            end else if (sync_s[3] && !ignore_rsts) begin
                busy <= 1'b1; is_slow <= 1'b1; run_cnt <= RUN_LEN; test_in_progress <= 1'b1;
            end
        end
    end

    // Event monitor: 0 rstf rise, 1 rsts rise, 2 rstf fall, 3 rsts fall, 4 tip fall.
    int         cyc = 0;
    int         ev[5] = '{default: 0};
    logic [7:0] req_q[$];
    logic       p_rstf = 1'b0, p_rsts = 1'b0, p_tip = 1'b0;
    int         fast_fall_cyc = 0, rsts_rise_cyc = 0, tip_rise_cyc = 0, rsts_fall_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rstf && !p_rstf) begin ev[0]++; req_q.push_back("F"); end
        if (rsts && !p_rsts) begin ev[1]++; req_q.push_back("S"); rsts_rise_cyc = cyc; end
        if (!rstf && p_rstf) ev[2]++;
        if (!rsts && p_rsts) begin ev[3]++; rsts_fall_cyc = cyc; end
        if (!test_in_progress && p_tip) begin ev[4]++; if (!is_slow) fast_fall_cyc = cyc; end
        if (test_in_progress && !p_tip) tip_rise_cyc = cyc;
        p_rstf = rstf;
        p_rsts = rsts;
        p_tip  = test_in_progress;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_evt(input string tag, input int sel, input int budget);
        int   start = ev[sel];
        logic got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ev[sel] != start) begin got = 1'b1; break; end
        end
        check_eq({tag, "_seen"}, 32'(got), 32'd1);
    endtask

    task automatic wait_pc(input string tag, input logic [7:0] target, input int budget);
        logic got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pass_count == target) begin got = 1'b1; break; end
        end
        check_eq({tag, "_seen"}, 32'(got), 32'd1);
    endtask

    task automatic btn_pulse(input int low, input int high);
        btn_n = 1'b0;
        wait_cycles(low);
        btn_n = 1'b1;
        wait_cycles(high);
    endtask

    function automatic logic [7:0] log_at(input int i);
        return (i >= 0 && i < req_q.size()) ? req_q[i] : 8'd0;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got 0 expected 1 (simulation did not finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        string exp_s;
        int    ones;
        int    n0;
        int    pc0;
        int    nlog;
        int    k;
        int    busy_cnt;

        // Reset values
        wait_cycles(3);
        check_eq("rst_rstf", 32'(rstf), 32'd0);
        check_eq("rst_rsts", 32'(rsts), 32'd0);
        check_eq("rst_hold", 32'(hold), 32'd0);
        check_eq("rst_pass_count", 32'(pass_count), 32'd0);
        check_eq("rst_fail_fast", 32'(fail_fast), 32'd0);
        check_eq("rst_fail_slow", 32'(fail_slow), 32'd0);
        check_eq("rst_err_timeout", 32'(err_timeout), 32'd0);
        check_eq("rst_running", 32'(running), 32'd1);
        check_eq("rst_led", 32'(led), 32'd0);

        // Power-up: tester already runs a fast pass, sequencer must join it
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_eq("boot_no_rstf", 32'(rstf), 32'd0);

        // All passes succeed
        wait_evt("first_rsts_rise", 1, 200);
        check_eq("fall_to_rsts_lat", 32'(rsts_rise_cyc - fast_fall_cyc), 32'd2);
        wait_evt("first_rsts_fall", 3, 100);
        check_eq("req_drop_lat", 32'(rsts_fall_cyc - tip_rise_cyc), 32'd1);
        wait_pc("pc3", 8'd3, 2000);
        check_eq("pass3_flags", 32'({fail_fast, fail_slow, err_timeout}), 32'd0);
        check_eq("pass3_running", 32'(running), 32'd1);
        exp_s = "SFSFS";
        check_eq("req_log_len", 32'(req_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) check_eq($sformatf("req_order_%0d", i), 32'(log_at(i)), 32'(exp_s[i]));
        ones = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (led) ones++; end
        check_eq("led_toggles", 32'((ones > 0) && (ones < 40)), 32'd1);

        // Reset while tester idle: the stale (failing) run must not be recorded
        fail_all = 1'b1;
        wait_evt("stale_tip_fall", 4, 300);
        rst = 1'b1;
        fail_all = 1'b0;
        wait_cycles(6);
        fail_slow_at = slow_runs + 2;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rearm_rstf", 32'(rstf), 32'd1);
        check_eq("rearm_rsts", 32'(rsts), 32'd0);
        check_eq("rearm_pass_count", 32'(pass_count), 32'd0);
        check_eq("rearm_flags", 32'({fail_fast, fail_slow, err_timeout}), 32'd0);

        // Slow pass fails on the second pair
        k = 0;
        for (int i = 0; i < 3000; i++) begin @(negedge clk); if (!running) begin k = 1; break; end end
        check_eq("stop_seen", 32'(k), 32'd1);
        check_eq("stop_fail_slow", 32'(fail_slow), 32'd1);
        check_eq("stop_fail_fast", 32'(fail_fast), 32'd0);
        check_eq("stop_err_timeout", 32'(err_timeout), 32'd0);
        check_eq("stop_pass_count", 32'(pass_count), 32'd1);
        wait_cycles(3);
        check_eq("stop_led", 32'(led), 32'd0);
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin @(negedge clk); if (rstf || rsts || running) busy_cnt++; end
        check_eq("stopped_idle", 32'(busy_cnt), 32'd0);

        // Press from STOPPED clears statistics and restarts
        fail_slow_at = 0;
        n0 = ev[0];
        btn_pulse(15, 4);
        check_eq("press_running", 32'(running), 32'd1);
        check_eq("press_pass_count", 32'(pass_count), 32'd0);
        check_eq("press_fail_slow", 32'(fail_slow), 32'd0);
        check_eq("press_rstf_rises", 32'(ev[0] - n0), 32'd1);

        // Bounce shorter than the debounce window during RUN_S is ignored
        wait_pc("pc1", 8'd1, 600);
        wait_evt("bounce_run_s", 3, 400);
        btn_pulse(3, 2);
        btn_pulse(5, 2);
        btn_pulse(2, 2);
        wait_evt("bounce_rstf", 0, 200);
        check_eq("bounce_pass_count", 32'(pass_count), 32'd2);

        // Real press during RUN_S acts only at CHECK
        wait_evt("press_run_s", 3, 400);
        btn_pulse(3, 2);
        btn_pulse(14, 2);
        check_eq("midrun_tip", 32'(test_in_progress), 32'd1);
        check_eq("midrun_reqs", 32'({rstf, rsts}), 32'd0);
        check_eq("midrun_pass_count", 32'(pass_count), 32'd2);
        wait_evt("press_rstf", 0, 200);
        check_eq("cleared_pass_count", 32'(pass_count), 32'd0);
        check_eq("cleared_flags", 32'({fail_fast, fail_slow, err_timeout}), 32'd0);

        // Pause mid RUN_F
        wait_evt("pause_run_f", 2, 300);
        wait_cycles(5);
        pc0 = 32'(pass_count);
        nlog = req_q.size();
        pause = 1'b1;
        @(negedge clk);
        check_eq("hold_lat1", 32'(hold), 32'd0);
        @(negedge clk);
        check_eq("hold_lat2", 32'(hold), 32'd1);
        wait_cycles(30);
        check_eq("paused_tip", 32'(test_in_progress), 32'd1);
        check_eq("paused_reqs", 32'({rstf, rsts}), 32'd0);
        check_eq("paused_pass_count", 32'(pass_count), 32'(pc0));
        pause = 1'b0;
        wait_evt("resume_rstf", 0, 600);
        check_eq("resume_pass_count", 32'(pass_count), 32'(pc0 + 1));
        check_eq("resume_log_len", 32'(req_q.size()), 32'(nlog + 2));
        check_eq("resume_log_s", 32'(log_at(nlog)), 32'("S"));
        check_eq("resume_log_f", 32'(log_at(nlog + 1)), 32'("F"));

        // Tester ignores slow restart: timeout
        ignore_rsts = 1'b1;
        wait_evt("tmo_rsts_rise", 1, 600);
        k = 0;
        for (int i = 1; i <= 100; i++) begin @(negedge clk); if (err_timeout) begin k = i; break; end end
        check_eq("tmo_latency", 32'(k), 32'd32);
        check_eq("tmo_rsts", 32'(rsts), 32'd0);
        check_eq("tmo_running", 32'(running), 32'd0);
        wait_cycles(3);
        check_eq("tmo_led", 32'(led), 32'd0);

        // Press clears the timeout flag
        ignore_rsts = 1'b0;
        btn_pulse(15, 4);
        check_eq("tmo_clear_err", 32'(err_timeout), 32'd0);
        check_eq("tmo_clear_running", 32'(running), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ramtest_sequencer.md
# ramtest_sequencer

Control and reporting stage wrapped around the 8-bit SRAM tester. Drives the tester's fast/slow restart requests (`rstf`/`rsts`) and its `hold` input, and consumes its `test_in_progress`/`test_result` outputs. It runs fast and slow passes back-to-back, accumulates pass count and sticky failure flags, and drives a status LED. It sits between board I/O (button, pause switch, LED) and the tester, all in the tester's clock domain.

## Interface
- `DEBOUNCE_CYCLES`, default 65536: stable cycles required on `btn_n` before a press is accepted.
- `START_TIMEOUT`, default 1024: cycles allowed between asserting a restart request and seeing `test_in_progress`=1.
- `BLINK_BITS`, default 22: width of the free-running LED blink counter; the blink phase is the counter MSB.
- `STOP_ON_FAIL`, default 1: 1 halts sequencing after the first failing pass; 0 keeps looping.
- `clk`  in  1  system clock, same clock as the tester.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_n`  in  1  asynchronous active-low button; a press clears statistics and restarts.
- `pause`  in  1  asynchronous pause switch.
- `test_in_progress`  in  1  from the tester, synchronous to `clk`.
- `test_result`  in  1  from the tester; valid when `test_in_progress`=0.
- `rstf`  out  1  fast-restart request to the tester.
- `rsts`  out  1  slow-restart request to the tester.
- `hold`  out  1  freezes the tester.
- `pass_count`  out  8  completed fast+slow pairs with both passing; saturates at 255.
- `fail_fast`, `fail_slow`  out  1 each  sticky failure flags.
- `err_timeout`  out  1  sticky; the tester did not start.
- `running`  out  1  high in any state except STOPPED.
- `led`  out  1  status LED.

## Operation
- Reset values: `rstf`=`rsts`=0, `hold`=0, `pass_count`=0, all flags 0, `running`=1, `led`=0. State is WAIT_FIRST.
- `pause` passes through a 2-flop synchronizer and drives `hold` directly.
- `btn_n` passes through a 2-flop synchronizer and a debouncer. A stable falling level sets `press_pending`.
- The state machine advances only while `hold`=0. States:
  - WAIT_FIRST. On the first cycle after reset: if `test_in_progress`=1, go to RUN_F, because the tester auto-starts fast at power-up. If it is 0, go to START_F and record nothing.
  - START_F / START_S. Hold `rstf` (respectively `rsts`) high and reload the timeout counter on entry. When `test_in_progress`=1, drop the request and go to RUN_F / RUN_S. If the counter expires first, set `err_timeout`, drop the request and go to STOPPED.
  - RUN_F. When `test_in_progress`=0, latch `fast_ok`=`test_result`. If it is 0, set `fail_fast`. Then go to CHECK.
  - RUN_S. When `test_in_progress`=0, handle `test_result` the same way, setting `fail_slow` on 0. If both passes were OK, increment `pass_count`, saturating. Then go to CHECK.
  - CHECK. This is the record point.
    - If `press_pending`=1: clear `pass_count`, all flags and `press_pending`, then go to START_F.
    - Else, if STOP_ON_FAIL=1 and any fail flag is set: go to STOPPED.
    - Else: coming from RUN_F go to START_S; coming from RUN_S go to START_F.
  - STOPPED. `running`=0. A press clears statistics and goes to START_F.
- Restart requests stay high until acknowledged. The tester samples them through its own 2-flop synchronizer, only on its clock-enable cycles in slow mode, so a single-cycle pulse is forbidden.
- `rstf` and `rsts` are never high together.
- A tester run cannot be aborted. A press during RUN_F or RUN_S takes effect at the next CHECK.
- `led` behaviour:
  - `running`=1 and no flags set: blink phase.
  - Any flag set: 0.
  - STOPPED with no flags set: 1.

## Timing
- `hold` follows `pause` with 2 cycles of latency.
- From `test_in_progress` falling in RUN_F to `rsts` rising: 2 cycles (RUN_F → CHECK → START_S, with `rsts` registered on the START_S entry).
- The request drops on the cycle after `test_in_progress`=1 is sampled.
- Timeout fires exactly START_TIMEOUT cycles after entering START_x, provided `hold` stays 0.
- Asserting `rst` mid-run forces the reset values immediately. The tester keeps running, and WAIT_FIRST handles that case.

## Structure
- Shared package `ramtest_pkg` holds:
  - the state encoding (WAIT_FIRST, START_F, RUN_F, START_S, RUN_S, CHECK, STOPPED);
  - default values for DEBOUNCE_CYCLES, START_TIMEOUT and BLINK_BITS.
- One sub-module, `btn_debounce`: synchronizer, stability counter, and a one-cycle press pulse output.

## Test plan
Bench uses a behavioural tester model with a small address range, a 4-cycle synchronizer, and a parameterizable result. Set DEBOUNCE_CYCLES=8 and START_TIMEOUT=32.
- Tester passes every run → ordering is RUN_F, START_S, RUN_S, START_F. After 3 pairs `pass_count`=3, flags 0, `led` toggles.
- Slow pass fails on the 2nd pair with STOP_ON_FAIL=1 → `fail_slow`=1, `pass_count`=1, state STOPPED, `running`=0, `led`=0.
- Model ignores `rsts` → `err_timeout`=1 exactly 32 cycles after `rsts` rose, `rsts`=0, STOPPED.
- Press `btn_n` during RUN_S with bounce shorter than 8 cycles → no action mid-run. At CHECK, counters clear and `rstf` rises.
- `pause`=1 mid-run → `hold`=1 two cycles later, state frozen. Release → sequencing resumes with no lost or duplicated record.
- Assert `rst` while the tester is halted (`test_in_progress`=0) → WAIT_FIRST goes to START_F, and no result is recorded for the stale run.
